// File: rtl/uart_pkg.sv
// Shared types, defaults and baud divisor helper for the UART stages.
package uart_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ   = 100_000_000;
  localparam int unsigned DEFAULT_BAUD       = 9600;
  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Clocks per oversample tick; never below 1 so the tick counter stays legal.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    int unsigned d;
    d = clk_freq / (baud * oversample);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick generator, shared by the receive and transmit stages.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int unsigned BAUD       = DEFAULT_BAUD,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  // Count 0..DIV-1 and raise a one-clock tick each time the count wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_cnt == LAST);
      if (r_cnt == LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver with a 4-byte shift buffer feeding the seven-segment stage.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int unsigned BAUD       = DEFAULT_BAUD,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        clear,
  output logic [31:0] rxbuf,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic [2:0]  rx_count
);

  localparam int unsigned SC_W = $clog2(OVERSAMPLE);
  localparam logic [SC_W-1:0] MID     = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] LAST_SC = SC_W'(OVERSAMPLE - 1);
  localparam logic [2:0]      LAST_BIT  = 3'd7;
  localparam logic [2:0]      COUNT_MAX = 3'd4;

  logic            w_tick;
  logic            r_rx_meta;
  logic            r_rxs;
  rx_state_t       r_state;
  logic [SC_W-1:0] r_sc;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_sr;
  logic            r_done;
  logic            r_frame_err;
  logic [31:0]     r_rxbuf;
  logic [7:0]      r_rx_data;
  logic            r_rx_valid;
  logic [2:0]      r_rx_count;

  baud_tick_gen #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
    end
  end

  // Frame FSM: start qualification at half-bit, data/stop sampled mid-bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sc        <= '0;
      r_bit_idx   <= '0;
      r_sr        <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_rxs) begin
            r_state   <= START;
            r_sc      <= '0;
            r_bit_idx <= '0;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_sc == MID) begin
              r_sc    <= '0;
              r_state <= r_rxs ? IDLE : DATA;
            end else begin
              r_sc <= r_sc + 1'b1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_sc == LAST_SC) begin
              r_sc      <= '0;
              r_sr      <= {r_rxs, r_sr[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
              if (r_bit_idx == LAST_BIT) begin
                r_state <= STOP;
              end
            end else begin
              r_sc <= r_sc + 1'b1;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_sc == LAST_SC) begin
              r_sc <= '0;
              if (r_rxs) begin
                r_done  <= 1'b1;
                r_state <= IDLE;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= BREAK;
              end
            end else begin
              r_sc <= r_sc + 1'b1;
            end
          end
        end
        BREAK: begin
          if (r_rxs) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Commit a finished byte into the buffer; clear wins over history but not over the new byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxbuf    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_count <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      if (r_done) begin
        r_rx_data  <= r_sr;
        r_rx_valid <= 1'b1;
        if (clear) begin
          r_rxbuf    <= {24'h0, r_sr};
          r_rx_count <= 3'd1;
        end else begin
          r_rxbuf    <= {r_rxbuf[23:0], r_sr};
          r_rx_count <= (r_rx_count == COUNT_MAX) ? COUNT_MAX : r_rx_count + 3'd1;
        end
      end else if (clear) begin
        r_rxbuf    <= '0;
        r_rx_count <= '0;
      end
    end
  end

  assign rxbuf     = r_rxbuf;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign rx_count  = r_rx_count;

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
- 8N1 UART receiver; feeds the seven-segment display stage.
- Recovers bytes from the serial rx pin using 16x oversampling.
- Shifts each good byte into a 4-byte receive buffer; the display stage shows that buffer byte-by-byte.
- Also reports a per-byte strobe, a frame-error strobe and a saturating byte count.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- OVERSAMPLE, 16, sample ticks per bit. Must be even and at least 4.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; idle high; asynchronous to clk.
- clear  input  1  synchronous clear of rxbuf and rx_count.
- rxbuf  output  32  receive buffer: [7:0] newest byte, [31:24] oldest.
- rx_data  output  8  last good byte received.
- rx_valid  output  1  one-cycle pulse when rx_data and rxbuf update.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- rx_count  output  3  good bytes held in rxbuf; saturates at 4.

Behaviour:
- Reset values: rxbuf=0, rx_data=0, rx_valid=0, frame_err=0, rx_count=0. The internal synchronizer flops reset to 1. The FSM resets to IDLE and the tick counter to 0.
- Synchronizer: rx passes through two flops; all decisions use the synchronized value rxs.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer division (651 at the defaults).
  - A free-running counter counts 0..DIV-1 and emits a one-clk tick at DIV-1.
- The FSM advances only on tick cycles, except the IDLE->START entry, which happens on any clk cycle. Sample counter sc counts ticks within a bit; MID = OVERSAMPLE/2-1.
  - IDLE: rxs==0 -> START, with sc=0 and bit index=0.
  - START: on the tick where sc==MID: rxs==0 -> DATA with sc=0; otherwise a glitch -> IDLE with no output.
  - DATA:
    - Sample on the tick where sc==OVERSAMPLE-1 (mid-bit), then reset sc.
    - Store LSB first: shift register sr <= {rxs, sr[7:1]}.
    - After the 8th sample -> STOP.
  - STOP: sample on the tick where sc==OVERSAMPLE-1.
    - rxs==1: on the next clk, rx_data<=sr, rxbuf<={rxbuf[23:0],sr}, rx_valid=1 for one clk, rx_count<=min(rx_count+1,4). Then -> IDLE.
    - rxs==0: frame_err=1 for one clk; rxbuf, rx_data and rx_count are unchanged. Then -> BREAK.
  - BREAK: stay until rxs==1, then -> IDLE. A held-low line therefore yields exactly one frame_err and no false starts.
- Latency: rx_valid rises 1 clk after the stop-bit sample tick. That is about 9.5 bit times plus 2-3 clk after the rx falling edge.
- clear:
  - Sets rxbuf=0 and rx_count=0 on the next edge. rx_data and the FSM are unaffected.
  - If clear and a byte completion occur in the same cycle: rxbuf={24'h0,sr}, rx_count=1, and rx_valid still pulses.
- Buffer full: a 5th and later byte shifts out the oldest byte; rx_count stays 4.
- Reset asserted mid-frame: all state returns to reset values immediately and the partial byte is discarded. After release, the line is treated as idle.
- rx_valid and frame_err are never high in the same cycle.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP, BREAK}.
  - Constants DEFAULT_CLK_FREQ, DEFAULT_BAUD, DEFAULT_OVERSAMPLE.
  - Function for computing DIV.
- Sub-module baud_tick_gen (parameters CLK_FREQ, BAUD, OVERSAMPLE; ports clk, reset, tick). It is reusable by the future transmitter stage that consumes txbuf.
- The synchronizer, FSM and buffer stay in uart_rx_buffer.

Test Plan:
Bench parameters: CLK_FREQ=1_600_000, BAUD=10_000, OVERSAMPLE=16, giving DIV=10 and one bit = 160 clk.
- Single byte: send 8'hA5 (8N1) -> one rx_valid pulse; rx_data=8'hA5; rxbuf=32'h000000A5; rx_count=1; pulse lands 1515-1525 clk after the rx falling edge.
- Fill and overflow: send 11, 22, 33, 44 -> rxbuf=32'h11223344, rx_count=4. Then send 55 -> rxbuf=32'h22334455, rx_count=4.
- Start glitch: drive rx low for 30 clk, then high -> no rx_valid, no frame_err, FSM back in IDLE, rxbuf unchanged.
- Framing error and break: send 8'h3C with stop bit 0, hold rx low 320 clk, then idle and send 8'h3C correctly -> exactly one frame_err pulse, then one rx_valid with rxbuf=32'h0000003C.
- Reset mid-frame: assert reset during data bit 4 of 8'hFF -> all outputs 0 at once. Release, send 8'h5A -> rxbuf=32'h0000005A, rx_count=1.
- Clear collision: preload 2 bytes, then pulse clear on the exact rx_valid cycle of byte 8'h77 -> rxbuf=32'h00000077, rx_count=1.
